// File: rtl/traffic_light_monitor_pkg.sv
// Shared definitions for the traffic light monitor: phase encoding,
// fault codes, default phase lengths and the transition legality table.
package traffic_light_monitor_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned FCODE_W = 3;
    localparam int unsigned DWELL_W = 3;
    localparam int unsigned CYC_W   = 8;

    localparam int unsigned G_LEN_DEF = 4;
    localparam int unsigned R_LEN_DEF = 3;
    localparam int unsigned Y_LEN_DEF = 1;

    typedef enum logic [PHASE_W-1:0] {
        PH_G_R  = 3'd0,
        PH_Y_R  = 3'd1,
        PH_R_G  = 3'd2,
        PH_R_Y  = 3'd3,
        PH_Y_Y  = 3'd4,
        PH_DARK = 3'd5,
        PH_BAD  = 3'd7
    } phase_e;

    typedef enum logic [FCODE_W-1:0] {
        FC_NONE       = 3'd0,
        FC_PATTERN    = 3'd1,
        FC_TRANSITION = 3'd2,
        FC_SHORT      = 3'd3,
        FC_LONG       = 3'd4
    } fault_code_e;

    // Lamp bundle, head A in the upper three bits.
    typedef struct packed {
        logic a_green;
        logic a_yellow;
        logic a_red;
        logic b_green;
        logic b_yellow;
        logic b_red;
    } lamps_t;

    // Phases of the normal green/yellow/red rotation.
    function automatic logic is_normal(input phase_e p);
        return (p == PH_G_R) || (p == PH_Y_R) || (p == PH_R_G) || (p == PH_R_Y);
    endfunction

    // Phases of the blink pattern.
    function automatic logic is_blink(input phase_e p);
        return (p == PH_Y_Y) || (p == PH_DARK);
    endfunction

    // Allowed phase changes; the mode is the one seen alongside the old phase.
    function automatic logic legal_step(input phase_e from_ph, input phase_e to_ph,
                                        input logic blink);
        logic ok;
        ok = 1'b0;
        if (!blink) begin
            case (from_ph)
                PH_G_R:                   ok = (to_ph == PH_Y_R);
                PH_Y_R:                   ok = (to_ph == PH_R_G);
                PH_R_G:                   ok = (to_ph == PH_R_Y);
                PH_R_Y, PH_Y_Y, PH_DARK:  ok = (to_ph == PH_G_R);
                default:                  ok = 1'b0;
            endcase
        end else begin
            case (from_ph)
                PH_G_R, PH_Y_R, PH_R_G, PH_R_Y: ok = (to_ph == PH_Y_Y);
                PH_Y_Y:                         ok = (to_ph == PH_DARK);
                PH_DARK:                        ok = (to_ph == PH_Y_Y);
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Observation bus of the monitor.
//   master: drives mode and six lamp lines, reads the monitor results
//   slave : the monitor; reads lamps/mode, drives phase, fault,
//           fault_code and cycles_done
interface traffic_light_monitor_if;
    import traffic_light_monitor_pkg::*;

    logic               modo;
    logic               A_green;
    logic               A_yellow;
    logic               A_red;
    logic               B_green;
    logic               B_yellow;
    logic               B_red;
    logic [PHASE_W-1:0] phase;
    logic               fault;
    logic [FCODE_W-1:0] fault_code;
    logic [CYC_W-1:0]   cycles_done;

    modport master (
        output modo, A_green, A_yellow, A_red, B_green, B_yellow, B_red,
        input  phase, fault, fault_code, cycles_done
    );

    modport slave (
        input  modo, A_green, A_yellow, A_red, B_green, B_yellow, B_red,
        output phase, fault, fault_code, cycles_done
    );

endinterface

// File: rtl/lamp_decoder.sv
// Combinational lamp-pattern decoder.
//   lamps_i   : six lamp lines of heads A and B
//   phase_c_o : decoded phase, PH_BAD for any unlisted pattern
module lamp_decoder
    import traffic_light_monitor_pkg::*;
(
    input  lamps_t lamps_i,
    output phase_e phase_c_o
);

    always_comb begin
        phase_c_o = PH_BAD;
        case (lamps_i)
            6'b100_001: phase_c_o = PH_G_R;
            6'b010_001: phase_c_o = PH_Y_R;
            6'b001_100: phase_c_o = PH_R_G;
            6'b001_010: phase_c_o = PH_R_Y;
            6'b010_010: phase_c_o = PH_Y_Y;
            6'b000_000: phase_c_o = PH_DARK;
            default:    phase_c_o = PH_BAD;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light controller monitor: decodes the lamps every cycle, tracks
// how long each phase has been held, and flags pattern, transition and
// timing violations with a sticky first-fault code.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : slave side of traffic_light_monitor_if (lamps/mode in,
//           phase/fault/fault_code/cycles_done out, all registered)
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int unsigned G_LEN = G_LEN_DEF,
    parameter int unsigned R_LEN = R_LEN_DEF,
    parameter int unsigned Y_LEN = Y_LEN_DEF
) (
    input logic                    clk,
    input logic                    reset,
    traffic_light_monitor_if.slave bus
);

    localparam logic [DWELL_W-1:0] G_LEN_W = DWELL_W'(G_LEN);
    localparam logic [DWELL_W-1:0] R_LEN_W = DWELL_W'(R_LEN);
    localparam logic [DWELL_W-1:0] Y_LEN_W = DWELL_W'(Y_LEN);
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    function automatic logic [DWELL_W-1:0] phase_len(input phase_e p);
        logic [DWELL_W-1:0] len;
        case (p)
            PH_G_R:  len = G_LEN_W;
            PH_R_G:  len = R_LEN_W;
            default: len = Y_LEN_W;
        endcase
        return len;
    endfunction

    lamps_t lamps_c;
    phase_e dec_c;

    assign lamps_c = {bus.A_green, bus.A_yellow, bus.A_red,
                      bus.B_green, bus.B_yellow, bus.B_red};

    lamp_decoder u_lamp_decoder (
        .lamps_i   (lamps_c),
        .phase_c_o (dec_c)
    );

    phase_e             phase_q, phase_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               modo_q, modo_d;
    // Clear until the first post-reset sample: the reset G_R is only an
    // expected predecessor, not an observed phase with a real dwell.
    logic               seen_q, seen_d;
    logic               fault_q, fault_d;
    logic [FCODE_W-1:0] fault_code_q, fault_code_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;

    logic        changed_c;
    logic        legal_c;
    logic        own_mode_c;
    logic        pattern_c;
    logic        trans_c;
    logic        short_c;
    logic        long_c;
    fault_code_e code_c;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q      <= PH_G_R;
            dwell_q      <= DWELL_W'(1);
            modo_q       <= 1'b0;
            seen_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            cycles_q     <= '0;
        end else begin
            phase_q      <= phase_d;
            dwell_q      <= dwell_d;
            modo_q       <= modo_d;
            seen_q       <= seen_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            cycles_q     <= cycles_d;
        end
    end

    // Violation detection and next-state.
    always_comb begin
        phase_d      = dec_c;
        modo_d       = bus.modo;
        seen_d       = 1'b1;
        dwell_d      = DWELL_W'(1);
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        cycles_d     = cycles_q;
        code_c       = FC_NONE;

        changed_c  = (dec_c != phase_q);
        legal_c    = legal_step(phase_q, dec_c, modo_q);
        own_mode_c = (is_normal(phase_q) && !modo_q) || (is_blink(phase_q) && modo_q);
        pattern_c  = (dec_c == PH_BAD);
        trans_c    = changed_c && !legal_c;
        // Leaving blink for G_R is a mode switch and is never short; entering
        // Y_Y from a normal phase happens only with modo_q=1 and is skipped too.
        short_c    = changed_c && legal_c && seen_q &&
                     ((!modo_q && is_normal(phase_q) && (dwell_q < phase_len(phase_q))) ||
                      (is_blink(phase_q) && (dec_c != PH_G_R) && (dwell_q < Y_LEN_W)));
        // The new sample would push the dwell past the phase length.
        long_c     = !changed_c && seen_q && own_mode_c && (dwell_q >= phase_len(phase_q));

        if (seen_q && !changed_c) begin
            dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DWELL_W'(1);
        end

        if (pattern_c) begin
            code_c = FC_PATTERN;
        end else if (trans_c) begin
            code_c = FC_TRANSITION;
        end else if (short_c) begin
            code_c = FC_SHORT;
        end else if (long_c) begin
            code_c = FC_LONG;
        end

        if (!fault_q && (code_c != FC_NONE)) begin
            fault_d      = 1'b1;
            fault_code_d = code_c;
        end

        if ((phase_q == PH_R_Y) && (dec_c == PH_G_R) && !modo_q) begin
            cycles_d = cycles_q + CYC_W'(1);
        end
    end

    assign bus.phase       = phase_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fault_code_q;
    assign bus.cycles_done = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: each applied lamp vector
// queues its hand-derived expected outputs; a monitor pops one entry per
// clock edge and compares on the following falling edge.
module tb_traffic_light_monitor;
    import traffic_light_monitor_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    traffic_light_monitor_if bus ();

    traffic_light_monitor #(
        .G_LEN (4),
        .R_LEN (3),
        .Y_LEN (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic       f;
        logic [2:0] fc;
        logic [7:0] cd;
    } obs_t;

    localparam logic [5:0] L_GR   = 6'b100_001;
    localparam logic [5:0] L_YR   = 6'b010_001;
    localparam logic [5:0] L_RG   = 6'b001_100;
    localparam logic [5:0] L_RY   = 6'b001_010;
    localparam logic [5:0] L_YY   = 6'b010_010;
    localparam logic [5:0] L_DARK = 6'b000_000;
    localparam logic [5:0] L_BAD  = 6'b101_001;

    obs_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       exp_f  = 1'b0;
    logic [2:0] exp_fc = 3'd0;
    logic [7:0] exp_cd = 8'd0;
    string      scen   = "reset";

    function automatic obs_t observe();
        return {bus.phase, bus.fault, bus.fault_code, bus.cycles_done};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got phase=%0d fault=%0d code=%0d cycles=%0d, want phase=%0d fault=%0d code=%0d cycles=%0d",
                     name, $time, got.ph, got.f, got.fc, got.cd, want.ph, want.f, want.fc, want.cd);
        end
    endtask

    // Apply one lamp vector for one clock; new_fc is the fault this sample
    // raises (0 = none); inc marks a sample completing a normal cycle.
    task automatic step(input logic [5:0] l, input logic m, input logic [2:0] eph,
                        input logic [2:0] new_fc, input logic inc);
        {bus.A_green, bus.A_yellow, bus.A_red, bus.B_green, bus.B_yellow, bus.B_red} = l;
        bus.modo = m;
        if (inc) exp_cd = exp_cd + 8'd1;
        if ((new_fc != 3'd0) && !exp_f) begin
            exp_f  = 1'b1;
            exp_fc = new_fc;
        end
        exp_q.push_back({eph, exp_f, exp_fc, exp_cd});
        @(posedge clk);
        #1;
    endtask

    // Legal normal cycles: G_R x4, Y_R, R_G x3, R_Y.
    task automatic cycle_seq(input int reps, input logic first_inc);
        for (int r = 0; r < reps; r++) begin
            step(L_GR, 1'b0, 3'd0, 3'd0, (r > 0) || first_inc);
            for (int k = 0; k < 3; k++) step(L_GR, 1'b0, 3'd0, 3'd0, 1'b0);
            step(L_YR, 1'b0, 3'd1, 3'd0, 1'b0);
            for (int k = 0; k < 3; k++) step(L_RG, 1'b0, 3'd2, 3'd0, 1'b0);
            step(L_RY, 1'b0, 3'd3, 3'd0, 1'b0);
        end
    endtask

    // Let the last comparison finish, then pulse reset between clock edges.
    task automatic do_reset(input string next_scen);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check({scen, "/async_reset"}, observe(), '0);
        exp_q.delete();
        exp_f  = 1'b0;
        exp_fc = 3'd0;
        exp_cd = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check({scen, "/reset_hold"}, observe(), '0);
        scen  = next_scen;
        reset = 1'b1;
    endtask

    // Scoreboard monitor: the entry at the head belongs to the sample
    // captured at this rising edge.
    initial begin
        obs_t want;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                @(negedge clk);
                check(scen, observe(), want);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, required completion before 2000000");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        {bus.A_green, bus.A_yellow, bus.A_red, bus.B_green, bus.B_yellow, bus.B_red} = L_GR;
        bus.modo = 1'b0;
        #1;
        check("reset/initial", observe(), '0);
        repeat (2) @(posedge clk);
        #1;
        scen  = "legal_cycles";
        reset = 1'b1;

        cycle_seq(3, 1'b0);
        step(L_GR, 1'b0, 3'd0, 3'd0, 1'b1);

        do_reset("early_exit");
        for (int k = 0; k < 3; k++) step(L_GR, 1'b0, 3'd0, 3'd0, 1'b0);
        step(L_YR, 1'b0, 3'd1, 3'd3, 1'b0);
        step(L_RG, 1'b0, 3'd2, 3'd0, 1'b0);

        do_reset("overlong");
        for (int k = 0; k < 4; k++) step(L_GR, 1'b0, 3'd0, 3'd0, 1'b0);
        step(L_YR, 1'b0, 3'd1, 3'd0, 1'b0);
        for (int k = 0; k < 3; k++) step(L_RG, 1'b0, 3'd2, 3'd0, 1'b0);
        step(L_RG, 1'b0, 3'd2, 3'd4, 1'b0);
        step(L_RY, 1'b0, 3'd3, 3'd0, 1'b0);

        do_reset("mode_round_trip");
        step(L_GR,   1'b0, 3'd0, 3'd0, 1'b0);
        step(L_GR,   1'b1, 3'd0, 3'd0, 1'b0);
        step(L_YY,   1'b1, 3'd4, 3'd0, 1'b0);
        step(L_DARK, 1'b1, 3'd5, 3'd0, 1'b0);
        step(L_YY,   1'b1, 3'd4, 3'd0, 1'b0);
        step(L_DARK, 1'b0, 3'd5, 3'd0, 1'b0);
        step(L_GR,   1'b0, 3'd0, 3'd0, 1'b0);
        step(L_GR,   1'b0, 3'd0, 3'd0, 1'b0);

        do_reset("blink_long");
        step(L_GR, 1'b1, 3'd0, 3'd0, 1'b0);
        step(L_YY, 1'b1, 3'd4, 3'd0, 1'b0);
        step(L_YY, 1'b1, 3'd4, 3'd4, 1'b0);

        do_reset("bad_transition");
        step(L_GR, 1'b0, 3'd0, 3'd0, 1'b0);
        step(L_RG, 1'b0, 3'd2, 3'd2, 1'b0);

        do_reset("bad_pattern");
        step(L_GR,  1'b0, 3'd0, 3'd0, 1'b0);
        step(L_BAD, 1'b0, 3'd7, 3'd1, 1'b0);
        step(L_RG,  1'b0, 3'd2, 3'd2, 1'b0);
        step(L_GR,  1'b0, 3'd0, 3'd2, 1'b0);

        do_reset("wrap");
        cycle_seq(257, 1'b0);
        step(L_GR, 1'b0, 3'd0, 3'd0, 1'b1);
        step(L_RG, 1'b0, 3'd2, 3'd2, 1'b0);

        do_reset("done");

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter: G_LEN, default 4, number of cycles phase G_R lasts in normal mode.
REQ-002 Parameter: R_LEN, default 3, number of cycles phase R_G lasts in normal mode.
REQ-003 Parameter: Y_LEN, default 1, number of cycles Y_R, R_Y, Y_Y and DARK each last.
REQ-004 Port: clk, input, 1 bit, sole clock, rising edge.
REQ-005 Port: reset, input, 1 bit; one clock; reset is asynchronous and active-low.
REQ-006 Port: modo, input, 1 bit, mode seen by the controller under observation (0 = normal, 1 = blink).
REQ-007 Port: A_green, A_yellow, A_red, inputs, 1 bit each, lamp outputs of head A.
REQ-008 Port: B_green, B_yellow, B_red, inputs, 1 bit each, lamp outputs of head B.
REQ-009 Port: phase, output, 3 bits, registered decoded phase.
REQ-010 Port: fault, output, 1 bit, sticky violation flag.
REQ-011 Port: fault_code, output, 3 bits, code of the first violation.
REQ-012 Port: cycles_done, output, 8 bits, count of completed normal cycles.

Function
REQ-013 The block SHALL decode the lamp inputs each cycle into a phase:
- G_R=0: A green, B red
- Y_R=1: A yellow, B red
- R_G=2: A red, B green
- R_Y=3: A red, B yellow
- Y_Y=4: both yellow
- DARK=5: all six lamps off
- BAD=7: any other pattern
REQ-014 The phase output SHALL equal the decode of the lamps sampled at the previous rising edge (1-cycle latency).
REQ-015 The block SHALL keep a 3-bit dwell counter that loads 1 when the decoded phase differs from the previous one and otherwise increments, saturating at 7.
REQ-016 The block SHALL register modo as modo_q, aligned with the previous sample.
REQ-017 Legal transitions when modo_q=0 SHALL be: G_R->Y_R, Y_R->R_G, R_G->R_Y, R_Y->G_R, Y_Y->G_R, DARK->G_R.
REQ-018 Legal transitions when modo_q=1 SHALL be: any of {G_R, Y_R, R_G, R_Y}->Y_Y, Y_Y->DARK, DARK->Y_Y.
REQ-019 Fault code 1 (PATTERN) SHALL be raised when the decode is BAD.
REQ-020 Fault code 2 (TRANSITION) SHALL be raised when a phase change is not listed in REQ-017/REQ-018.
REQ-021 Fault code 3 (SHORT) SHALL be raised on a legal change with modo_q=0 out of a normal phase whose dwell was below its length, or on any change out of Y_Y or DARK whose dwell was below Y_LEN.
- Exempt: changes caused by a mode switch (normal->Y_Y, blink->G_R).
REQ-022 Fault code 4 (LONG) SHALL be raised when the dwell exceeds its phase length while the phase is unchanged and modo_q selects that phase's own mode.
REQ-023 Priority when several faults occur in one cycle SHALL be PATTERN > TRANSITION > SHORT > LONG.
REQ-024 fault SHALL set one cycle after detection and then hold.
REQ-025 fault_code SHALL latch the first fault only and ignore later faults until reset.
REQ-026 cycles_done SHALL increment on each legal R_Y->G_R transition.
REQ-027 cycles_done SHALL wrap from 255 to 0 and SHALL keep counting after a fault.

Reset
REQ-028 While reset=0: phase=G_R, dwell=1, modo_q=0, fault=0, fault_code=0, cycles_done=0; the expected predecessor SHALL be G_R, so a controller leaving reset in G_R is legal.
REQ-029 Reset assertion mid-operation SHALL clear all state immediately, independent of clk.

Structure
REQ-030 A shared package SHALL hold the phase encoding, the fault-code constants and the default phase lengths.
REQ-031 The lamp-pattern decode (REQ-013) SHALL be a sub-module, lamp_decoder.

Verification
REQ-032 Scenario "legal normal cycles":
- Stimulus: modo=0; lamps G_R x4, Y_R x1, R_G x3, R_Y x1, repeated 3 times.
- Required: fault=0; cycles_done=3.
REQ-033 Scenario "early exit":
- Stimulus: G_R held 3 cycles, then Y_R, with modo=0.
- Required: fault=1, fault_code=3.
REQ-034 Scenario "overlong phase":
- Stimulus: R_G held 4 cycles with modo=0.
- Required: fault=1, fault_code=4, raised one cycle after the 4th sample.
REQ-035 Scenario "mode switch round trip":
- Stimulus: modo 0->1 in the 2nd G_R cycle; then Y_Y, DARK, Y_Y alternating; then modo=0; then G_R.
- Required: fault=0.
REQ-036 Scenario "bad pattern plus later fault":
- Stimulus: A_green and A_red both 1; one cycle later an illegal transition.
- Required: phase=7; fault_code stays 1.
REQ-037 Scenario "wrap and async reset":
- Stimulus: 256 legal cycles, then reset pulsed low between edges.
- Required: cycles_done=0 after the wrap; all outputs at reset values before the next edge.
